// File: rtl/mem_packer_pkg.sv
// Shared types and constants for the 32-to-64-bit memory word packer.
package mem_packer_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam int         LINE_BYTES = 8;
   localparam logic [1:0] MASK_LO    = 2'b01;
   localparam logic [1:0] MASK_FULL  = 2'b11;

endpackage

// File: rtl/mem_word_packer.sv
// Packs pairs of 32-bit words into 64-bit memory line writes; a flush writes
// out a half-filled line with only the low lane enabled.
module mem_word_packer
   import mem_packer_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   input  logic              flush,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [1:0]        mem_wmask,
   input  logic              mem_ready,
   output logic              pending,
   output logic [15:0]       wr_count
);

   state_t              r_state;
   logic [31:0]         r_lo;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [63:0]         r_wdata;
   logic [1:0]          r_wmask;
   logic [15:0]         r_wr_count;
   logic                w_xfer;

   // WRITE blocks the producer; reset forces EMPTY, so in_ready reads 1 then.
   assign in_ready  = (r_state != WRITE);
   assign w_xfer    = in_valid & in_ready;
   assign pending   = (r_state == HALF);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wmask = r_wmask;
   assign wr_count  = r_wr_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= EMPTY;
         r_lo       <= '0;
         r_we       <= 1'b0;
         r_addr     <= BASE_ADDR;
         r_wdata    <= '0;
         r_wmask    <= 2'b00;
         r_wr_count <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_xfer && flush) begin
                  r_state <= WRITE;
                  r_we    <= 1'b1;
                  r_wdata <= {32'h0, in_data};
                  r_wmask <= MASK_LO;
               end else if (w_xfer) begin
                  r_state <= HALF;
                  r_lo    <= in_data;
               end
            end
            HALF: begin
               if (w_xfer) begin
                  r_state <= WRITE;
                  r_we    <= 1'b1;
                  r_wdata <= {in_data, r_lo};
                  r_wmask <= MASK_FULL;
               end else if (flush) begin
                  r_state <= WRITE;
                  r_we    <= 1'b1;
                  r_wdata <= {32'h0, r_lo};
                  r_wmask <= MASK_LO;
               end
            end
            WRITE: begin
               // Line outputs hold until memory takes them; the address wraps.
               if (mem_ready) begin
                  r_state    <= EMPTY;
                  r_we       <= 1'b0;
                  r_wdata    <= '0;
                  r_wmask    <= 2'b00;
                  r_addr     <= r_addr + ADDR_W'(LINE_BYTES);
                  r_wr_count <= r_wr_count + 16'd1;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_word_packer.sv
// Directed checks of the word packer: pairing, flush, back-pressure,
// address wrap on a narrow instance, and reset during a write.
module tb_mem_word_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, flush, mem_ready;
   logic [31:0] in_data;
   logic        in_ready, mem_we, pending;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [1:0]  mem_wmask;
   logic [15:0] wr_count;

   logic        n_in_valid, n_flush, n_mem_ready;
   logic [31:0] n_in_data;
   logic        n_in_ready, n_mem_we, n_pending;
   logic [3:0]  n_mem_addr;
   logic [63:0] n_mem_wdata;
   logic [1:0]  n_mem_wmask;
   logic [15:0] n_wr_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_word_packer #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .flush(flush), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
      .pending(pending), .wr_count(wr_count)
   );

   mem_word_packer #(.ADDR_W(4), .BASE_ADDR(4'h8)) dut_n (
      .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_data(n_in_data),
      .in_ready(n_in_ready), .flush(n_flush), .mem_we(n_mem_we), .mem_addr(n_mem_addr),
      .mem_wdata(n_mem_wdata), .mem_wmask(n_mem_wmask), .mem_ready(n_mem_ready),
      .pending(n_pending), .wr_count(n_wr_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_line(input string tag, input logic we, input logic [31:0] addr,
                           input logic [63:0] data, input logic [1:0] mask);
      chk({tag, "_we"},    64'(mem_we),    64'(we));
      chk({tag, "_addr"},  64'(mem_addr),  64'(addr));
      chk({tag, "_wdata"}, mem_wdata,      data);
      chk({tag, "_wmask"}, 64'(mem_wmask), 64'(mask));
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; flush = 1'b0; mem_ready = 1'b0;
      n_in_valid = 1'b0; n_in_data = '0; n_flush = 1'b0; n_mem_ready = 1'b0;

      // reset state; a word offered during reset must not be taken
      tick(); tick();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_pending",  64'(pending),  64'd0);
      chk("rst_count",    64'(wr_count), 64'd0);
      chk_line("rst", 1'b0, 32'h0, 64'h0, 2'b00);
      in_valid = 1'b0;
      reset = 1'b0;
      tick();
      chk("post_rst_pending", 64'(pending), 64'd0);

      // two consecutive words form one full line
      mem_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'hAAAA_0001;
      tick();
      chk("pair_pending", 64'(pending), 64'd1);
      chk("pair_we0",     64'(mem_we),  64'd0);
      in_data = 32'hBBBB_0002;
      tick();
      chk_line("pair", 1'b1, 32'h0, 64'hBBBB0002_AAAA0001, 2'b11);
      chk("pair_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      tick();
      chk_line("pair_done", 1'b0, 32'h8, 64'h0, 2'b00);
      chk("pair_count", 64'(wr_count), 64'd1);

      // one word, flush two cycles later
      in_valid = 1'b1; in_data = 32'h1234_5678;
      tick();
      chk("fl_pending1", 64'(pending), 64'd1);
      in_valid = 1'b0;
      tick();
      chk("fl_pending2", 64'(pending), 64'd1);
      chk("fl_we_hold",  64'(mem_we),  64'd0);
      flush = 1'b1;
      tick();
      chk_line("flush", 1'b1, 32'h8, 64'h00000000_12345678, 2'b01);
      chk("fl_pending3", 64'(pending), 64'd0);
      flush = 1'b0;
      tick();
      chk("fl_count", 64'(wr_count), 64'd2);
      chk("fl_addr",  64'(mem_addr), 64'h10);

      // memory stalls five cycles with the producer still offering
      mem_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1111_1111;
      tick();
      in_data = 32'h2222_2222;
      tick();
      in_data = 32'h3333_3333;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk_line("stall", 1'b1, 32'h10, 64'h22222222_11111111, 2'b11);
      end
      mem_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_line("stall_done", 1'b0, 32'h18, 64'h0, 2'b00);
      chk("stall_count",   64'(wr_count), 64'd3);
      chk("stall_pending", 64'(pending),  64'd0);

      // flush alone in EMPTY does nothing
      flush = 1'b1;
      tick();
      tick();
      chk("empty_flush_we",    64'(mem_we),   64'd0);
      chk("empty_flush_count", 64'(wr_count), 64'd3);
      chk("empty_flush_pend",  64'(pending),  64'd0);

      // word plus flush in HALF makes one full line, no extra half write
      flush = 1'b0; in_valid = 1'b1; in_data = 32'h4444_4444;
      tick();
      in_data = 32'h5555_5555; flush = 1'b1;
      tick();
      chk_line("half_fl", 1'b1, 32'h18, 64'h55555555_44444444, 2'b11);
      in_valid = 1'b0;
      tick();
      chk("half_fl_count", 64'(wr_count), 64'd4);
      flush = 1'b0;
      tick();
      chk("half_fl_noextra", 64'(mem_we),   64'd0);
      chk("half_fl_count2",  64'(wr_count), 64'd4);

      // word plus flush in EMPTY writes the low lane only
      in_valid = 1'b1; in_data = 32'h6666_6666; flush = 1'b1;
      tick();
      chk_line("empty_wfl", 1'b1, 32'h20, 64'h00000000_66666666, 2'b01);
      in_valid = 1'b0; flush = 1'b0;
      tick();
      chk("empty_wfl_count", 64'(wr_count), 64'd5);
      chk("empty_wfl_addr",  64'(mem_addr), 64'h28);

      // reset during WRITE drops the line asynchronously
      mem_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h7777_7777; flush = 1'b1;
      tick();
      chk("rw_we", 64'(mem_we), 64'd1);
      in_valid = 1'b0; flush = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rw_async_we",    64'(mem_we),   64'd0);
      chk("rw_async_count", 64'(wr_count), 64'd0);
      mem_ready = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk_line("rw_after", 1'b0, 32'h0, 64'h0, 2'b00);
      chk("rw_after_count", 64'(wr_count), 64'd0);

      // narrow address: base 8, second line wraps to 0
      n_mem_ready = 1'b1;
      n_in_valid = 1'b1; n_in_data = 32'h0000_0001;
      tick();
      n_in_data = 32'h0000_0002;
      tick();
      chk("wrap_we1",   64'(n_mem_we),   64'd1);
      chk("wrap_addr1", 64'(n_mem_addr), 64'h8);
      n_in_valid = 1'b0;
      tick();
      chk("wrap_addr_after1", 64'(n_mem_addr), 64'h0);
      n_in_valid = 1'b1; n_in_data = 32'h0000_0003;
      tick();
      n_in_data = 32'h0000_0004;
      tick();
      chk("wrap_we2",    64'(n_mem_we),    64'd1);
      chk("wrap_addr2",  64'(n_mem_addr),  64'h0);
      chk("wrap_wdata2", n_mem_wdata,      64'h00000004_00000003);
      n_in_valid = 1'b0;
      tick();
      chk("wrap_count", 64'(n_wr_count), 64'd2);
      chk("wrap_addr3", 64'(n_mem_addr), 64'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_word_packer.md
MEM_WORD_PACKER -- requirements
Module: mem_word_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of the byte address of a 64-bit memory line.
REQ-002 SHALL have parameter BASE_ADDR, default 0: first line address after reset; an 8-byte-aligned value.
REQ-003 SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: producer offers in_data this cycle.
REQ-006 SHALL have port in_data, input, 32: instruction/data word offered.
REQ-007 SHALL have port in_ready, output, 1: packer accepts a word at the next edge when in_valid=1.
REQ-008 SHALL have port flush, input, 1: request to write out a half-filled line.
REQ-009 SHALL have port mem_we, output, 1: registered write strobe to memory.
REQ-010 SHALL have port mem_addr, output, ADDR_W: registered line byte address, bits [2:0] always 0.
REQ-011 SHALL have port mem_wdata, output, 64: registered line data, first word in [31:0], second word in [63:32].
REQ-012 SHALL have port mem_wmask, output, 2: lane enables, bit0 = [31:0], bit1 = [63:32].
REQ-013 SHALL have port mem_ready, input, 1: memory accepts the current write at this edge.
REQ-014 SHALL have port pending, output, 1: exactly one word held, no write issued.
REQ-015 SHALL have port wr_count, output, 16: number of completed line writes, wraps at 2^16.

Function
REQ-016 SHALL implement a three-state FSM: EMPTY, HALF, WRITE.
REQ-017 SHALL drive in_ready = 1 in EMPTY and HALF and 0 in WRITE; transfer = in_valid & in_ready at a rising edge.
REQ-018 EMPTY: transfer without flush SHALL store in_data in low slot and go to HALF.
REQ-019 EMPTY: transfer with flush SHALL go to WRITE with wdata = {32'h0, in_data} and wmask = 2'b01.
REQ-020 EMPTY: flush without transfer SHALL be a no-op.
REQ-021 HALF: transfer, with or without flush, SHALL go to WRITE with wdata = {in_data, low slot} and wmask = 2'b11.
REQ-022 HALF: flush without transfer SHALL go to WRITE with wdata = {32'h0, low slot} and wmask = 2'b01.
REQ-023 HALF: no transfer and no flush SHALL hold state and slot indefinitely.
REQ-024 WRITE: mem_we SHALL be 1, and mem_addr, mem_wdata and mem_wmask SHALL stay stable until an edge with mem_ready=1.
REQ-025 WRITE: at the edge with mem_ready=1, the block SHALL go to EMPTY, add 8 to mem_addr modulo 2^ADDR_W, increment wr_count, and clear mem_we, mem_wdata and mem_wmask to 0.
REQ-026 WRITE: flush SHALL be ignored.
REQ-027 Latency: mem_we SHALL rise in the cycle after the completing transfer or flush edge; minimum throughput is 2 words per 3 cycles with mem_ready tied high.
REQ-028 pending SHALL equal (state == HALF); it is a combinational decode of registered state.
REQ-029 mem_ready outside WRITE SHALL be ignored.

Reset
REQ-030 Reset SHALL force: state EMPTY, low slot 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, mem_wmask 2'b00, wr_count 0, pending 0.
REQ-031 in_ready SHALL read 1 while reset is high; no transfer is taken while reset is high.
REQ-032 Reset mid-WRITE SHALL drop the line without completing it: mem_we falls immediately (asynchronously) and wr_count is not incremented.

Structure
REQ-033 Package mem_packer_pkg SHALL hold: state enum (EMPTY, HALF, WRITE), LINE_BYTES = 8, and mask constants MASK_LO = 2'b01 and MASK_FULL = 2'b11.
REQ-034 The block SHALL be a single module with no sub-modules; the FSM and datapath together are 120-400 RTL lines.

Verification
REQ-035 Words 0xAAAA0001 and 0xBBBB0002 on consecutive cycles, mem_ready=1 -> one write: addr 0x0, wdata 0xBBBB0002_AAAA0001, wmask 11; wr_count=1.
REQ-036 One word 0x12345678, then flush two cycles later -> write: addr 0x0, wdata 0x00000000_12345678, wmask 01; pending=1 between the accept and the flush.
REQ-037 mem_ready held low for 5 cycles during WRITE, in_valid=1 throughout -> in_ready=0 and mem outputs stable for all 5 cycles; the write completes at the first mem_ready=1 edge.
REQ-038 ADDR_W=4, BASE_ADDR=8, two full lines -> first write at addr 0x8, second at 0x0 (address wraps).
REQ-039 Flush with in_valid in HALF -> full write with wmask 11, no extra half write; flush alone in EMPTY -> no write.
REQ-040 Reset asserted during WRITE -> mem_we drops the same cycle and wr_count stays 0; after release, mem_addr equals BASE_ADDR.
